dmi_arbiter: RTL
================

Name: dmi_arbiter

Overview:
- Shares the single core-side DMI request/response port of the debug module between NumReq DMI requesters, e.g. the JTAG DTM after the CDC and an on-chip debug host.
- Round-robin arbitration with exactly one transaction outstanding at a time. Each response is routed back to the requester that issued the request.
- Sits in the clk_i domain, between the DMI CDC outputs / other hosts and the dm_top DMI slave port.

Parameters:
- NumReq, 2, number of requesters (>=2).
- TimeoutCycles, 1024, response watchdog limit in clk_i cycles; used only with DMI_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NumReq x dm::dmi_req_t (41b)  per-requester request {addr[6:0], op[1:0], data[31:0]}.
- req_valid_i  in  NumReq  request valid per requester.
- req_ready_o  out  NumReq  request accepted.
- resp_o  out  dm::dmi_resp_t (34b)  response {data[31:0], resp[1:0]}, shared by all requesters.
- resp_valid_o  out  NumReq  response valid, one-hot to the owning requester.
- resp_ready_i  in  NumReq  requester ready for its response.
- dmi_req_o  out  dm::dmi_req_t  to DM.
- dmi_req_valid_o  out  1.
- dmi_req_ready_i  in  1.
- dmi_resp_i  in  dm::dmi_resp_t  from DM.
- dmi_resp_valid_i  in  1.
- dmi_resp_ready_o  out  1.

Behaviour:
- FSM states are IDLE, REQ, RESP, RET. Reset enters IDLE and clears every output to 0: valids, readies, resp_o and dmi_req_o.
- Round-robin pointer last_q is reset to NumReq-1, so requester 0 wins first.
- IDLE:
  - Grant is combinational: the first i with req_valid_i[i]=1, searching from last_q+1 and wrapping modulo NumReq.
  - req_ready_o[grant]=1; all other ready bits are 0.
  - On the handshake, register req_i[grant] into the request register, set owner_q=grant and last_q=grant, then go to REQ.
  - With no valid request, stay in IDLE and drive all ready bits to 0.
- REQ:
  - dmi_req_valid_o=1 and dmi_req_o=request register, both stable until dmi_req_ready_i.
  - On handshake, go to RESP. Minimum latency from requester accept to DM valid is 1 cycle.
- RESP:
  - dmi_resp_ready_o=1.
  - On dmi_resp_valid_i, register dmi_resp_i and go to RET.
- RET:
  - resp_valid_o[owner_q]=1 and resp_o=response register, held until resp_ready_i[owner_q].
  - Then go to IDLE. A new grant is possible in the very next cycle.
- dmi_resp_ready_o is 0 outside RESP. req_ready_o is 0 outside IDLE. No request is ever dropped or reordered.
- Every op gets exactly one response, including NOP (0), READ (1) and WRITE (2).
- A requester that drops valid before it is granted loses no state.
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NumReq-1 transactions.
- Async reset mid-transaction:
  - FSM returns to IDLE immediately and all valids deassert.
  - The in-flight transaction is abandoned and no response is returned.
  - The DM side is reset by the same rst_i.
- No combinational paths from dmi_* inputs to dmi_* outputs.

Optional Feature:
- Macro: DMI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or RESP, saturating.
  - When the count reaches TimeoutCycles-1 without a DM response, load the response register with {data=32'h0, resp=2'h2 (DTM_ERR)}, go to RET, and set a drain flag.
  - While the drain flag is set and no transaction is in REQ or RESP, dmi_resp_ready_o=1. The first dmi_resp_valid_i consumes and discards the late response and clears the flag.
  - A timeout that occurs in REQ also deasserts dmi_req_valid_o.
- Undefined: no counter and no drain logic; the arbiter waits indefinitely.

Test Plan:
- Single requester 0 READ addr 7'h11:
  - DM answers data 32'hDEADBEEF, resp 0 after 3 cycles.
  - resp_valid_o=2'b01 with that data.
  - dmi_req_valid_o rises 1 cycle after accept.
- Both requesters valid continuously, 6 transactions: grant order 0,1,0,1,0,1. resp_valid_o is never asserted on the non-owner.
- Backpressure:
  - dmi_req_ready_i held low 5 cycles: dmi_req_o stays stable and req_ready_o stays 0.
  - resp_ready_i[1] held low 4 cycles: resp_o stays stable and no new grant is issued.
- rst_i asserted while in RESP: all outputs 0 in the same cycle. After release, requester 0 wins first and completes normally.
- WRITE addr 7'h10 data 32'h1 from requester 1, then NOP from requester 0: exactly two DM transactions and two responses, in order.
- With DMI_ARB_TIMEOUT_EN and TimeoutCycles=16:
  - DM silent: requester receives resp 2'h2, data 0, 16 cycles after entering REQ.
  - A late DM response is consumed and not forwarded.
  - The next request completes normally.

Source files
------------

// File: rtl/dmi_arbiter_if.sv
// DMI payload types and the bundled requester/DM handshake interface for dmi_arbiter.
// slave = arbiter view, master = requesters plus debug-module environment view.
package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

interface dmi_arbiter_if #(
  parameter int unsigned NumReq = 2
);
  dm::dmi_req_t [NumReq-1:0] req_i;
  logic [NumReq-1:0]         req_valid_i;
  logic [NumReq-1:0]         req_ready_o;
  dm::dmi_resp_t             resp_o;
  logic [NumReq-1:0]         resp_valid_o;
  logic [NumReq-1:0]         resp_ready_i;
  dm::dmi_req_t              dmi_req_o;
  logic                      dmi_req_valid_o;
  logic                      dmi_req_ready_i;
  dm::dmi_resp_t             dmi_resp_i;
  logic                      dmi_resp_valid_i;
  logic                      dmi_resp_ready_o;

  modport slave (
    input  req_i, req_valid_i, resp_ready_i, dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    output req_ready_o, resp_o, resp_valid_o, dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );

  modport master (
    output req_i, req_valid_i, resp_ready_i, dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    input  req_ready_o, resp_o, resp_valid_o, dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI port among NumReq requesters, one transaction in flight.
// Optional response watchdog with late-response drain: `define DMI_ARB_TIMEOUT_EN.
module dmi_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input logic        clk_i,
  input logic        rst_i,
  dmi_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  if (NumReq < 2 || TimeoutCycles < 2) begin : g_param_check
    $error("dmi_arbiter: NumReq and TimeoutCycles must both be >= 2");
  end

  logic [1:0]        state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  dm::dmi_req_t      req_q, req_d;
  dm::dmi_resp_t     resp_q, resp_d;
  logic              dmi_req_valid_q, dmi_req_valid_d;
  logic              dmi_resp_ready_q, dmi_resp_ready_d;
  logic [NumReq-1:0] resp_valid_q, resp_valid_d;

  logic [IdxW-1:0]   grant_c;
  logic              found_c;
  logic [IdxW-1:0]   scan_idx;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLim = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drain_q, drain_d;
  logic            timeout_c;

  assign timeout_c = (cnt_q == CntLim);
`endif

  // First valid requester after last_q, wrapping around.
  always_comb begin
    grant_c  = last_q;
    found_c  = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      scan_idx = IdxW'((32'(last_q) + k) % NumReq);
      if (!found_c && bus.req_valid_i[scan_idx]) begin
        found_c = 1'b1;
        grant_c = scan_idx;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    owner_d         = owner_q;
    req_d           = req_q;
    resp_d          = resp_q;
    dmi_req_valid_d = dmi_req_valid_q;
    resp_valid_d    = resp_valid_q;
`ifdef DMI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    drain_d = drain_q;
    if ((state_q == REQ || state_q == RESP) && !timeout_c) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // A late response from an abandoned transaction is swallowed here.
    if (drain_q && dmi_resp_ready_q && bus.dmi_resp_valid_i &&
        (state_q == IDLE || state_q == RET)) begin
      drain_d = 1'b0;
    end
`endif

    case (state_q)
      IDLE: begin
        if (found_c) begin
          req_d           = bus.req_i[grant_c];
          owner_d         = grant_c;
          last_d          = grant_c;
          dmi_req_valid_d = 1'b1;
          state_d         = REQ;
`ifdef DMI_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      REQ: begin
        if (bus.dmi_req_ready_i) begin
          dmi_req_valid_d = 1'b0;
          state_d         = RESP;
        end
`ifdef DMI_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          dmi_req_valid_d = 1'b0;
          resp_d.data     = 32'h0;
          resp_d.resp     = 2'h2;
          resp_valid_d    = NumReq'(1) << owner_q;
          drain_d         = 1'b1;
          state_d         = RET;
        end
`endif
      end
      RESP: begin
        if (bus.dmi_resp_valid_i) begin
          resp_d       = bus.dmi_resp_i;
          resp_valid_d = NumReq'(1) << owner_q;
          state_d      = RET;
        end
`ifdef DMI_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          resp_d.data  = 32'h0;
          resp_d.resp  = 2'h2;
          resp_valid_d = NumReq'(1) << owner_q;
          drain_d      = 1'b1;
          state_d      = RET;
        end
`endif
      end
      RET: begin
        if (bus.resp_ready_i[owner_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef DMI_ARB_TIMEOUT_EN
    dmi_resp_ready_d = (state_d == RESP) ||
                       (drain_d && (state_d == IDLE || state_d == RET));
`else
    dmi_resp_ready_d = (state_d == RESP);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      last_q           <= IdxW'(NumReq - 1);
      owner_q          <= '0;
      req_q            <= '0;
      resp_q           <= '0;
      dmi_req_valid_q  <= 1'b0;
      dmi_resp_ready_q <= 1'b0;
      resp_valid_q     <= '0;
    end else begin
      state_q          <= state_d;
      last_q           <= last_d;
      owner_q          <= owner_d;
      req_q            <= req_d;
      resp_q           <= resp_d;
      dmi_req_valid_q  <= dmi_req_valid_d;
      dmi_resp_ready_q <= dmi_resp_ready_d;
      resp_valid_q     <= resp_valid_d;
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end
`endif

  // Ready is the only combinational output; held low while reset is asserted.
  assign bus.req_ready_o      = (state_q == IDLE && found_c && !rst_i) ?
                                (NumReq'(1) << grant_c) : '0;
  assign bus.resp_o           = resp_q;
  assign bus.resp_valid_o     = resp_valid_q;
  assign bus.dmi_req_o        = req_q;
  assign bus.dmi_req_valid_o  = dmi_req_valid_q;
  assign bus.dmi_resp_ready_o = dmi_resp_ready_q;

endmodule
